bt_tx_arbiter: RTL and testbench

BT_TX_ARBITER -- requirements
Module: bt_tx_arbiter

---
 rtl/bt_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_bt_tx_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bt_tx_arbiter.sv
// Three-requester byte arbiter feeding a UART transmitter through a LOAD/STROBE/WAIT handshake.
// Define BT_TX_ARB_FIXED_PRIO_EN for fixed priority (req[0] highest); round-robin otherwise.
module bt_tx_arbiter #(
    parameter int unsigned GUARD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic [7:0] data2,
    input  logic       txrdy,
    output logic [2:0] gnt,
    output logic [7:0] data_tx,
    output logic       wen
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STROBE,
        WAIT
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic       wen_q, wen_d;
    logic [7:0] data_q, data_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] win_idx;
    logic [7:0] win_data;

`ifdef BT_TX_ARB_FIXED_PRIO_EN
    always_comb begin
        if (req[0])      win_idx = 2'd0;
        else if (req[1]) win_idx = 2'd1;
        else             win_idx = 2'd2;
    end
`else
    logic [1:0] last_q, last_d;

    // Search starts just after the previous winner and wraps 2 -> 0.
    always_comb begin
        case (last_q)
            2'd0:    win_idx = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    win_idx = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: win_idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end
`endif

    always_comb begin
        case (win_idx)
            2'd0:    win_data = data0;
            2'd1:    win_data = data1;
            default: win_data = data2;
        endcase
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        gnt_d   = 3'b000;
        wen_d   = 1'b1;
        data_d  = data_q;
        cnt_d   = cnt_q;
`ifndef BT_TX_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if ((|req) && txrdy) begin
                    state_d = LOAD;
                    gnt_d   = 3'b001 << win_idx;
                    data_d  = win_data;
`ifndef BT_TX_ARB_FIXED_PRIO_EN
                    last_d  = win_idx;
`endif
                end
            end
            LOAD: begin
                state_d = STROBE;
                wen_d   = 1'b0;
            end
            STROBE: begin
                state_d = WAIT;
                cnt_d   = GUARD[3:0];
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (txrdy) state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 3'b000;
            wen_q   <= 1'b1;
            data_q  <= 8'h00;
            cnt_q   <= 4'd0;
`ifndef BT_TX_ARB_FIXED_PRIO_EN
            last_q  <= 2'd2;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            wen_q   <= wen_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
`ifndef BT_TX_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign wen     = wen_q;
    assign data_tx = data_q;

endmodule

// File: tb/tb_bt_tx_arbiter.sv
// Self-checking bench for bt_tx_arbiter: vector table plus hand sequences, scoreboard-checked.
module tb_bt_tx_arbiter;

    localparam int unsigned GUARD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = 3'b000;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic [7:0] data2 = 8'h00;
    logic       txrdy = 1'b0;
    logic [2:0] gnt;
    logic [7:0] data_tx;
    logic       wen;

    bt_tx_arbiter #(.GUARD(GUARD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .data0   (data0),
        .data1   (data1),
        .data2   (data2),
        .txrdy   (txrdy),
        .gnt     (gnt),
        .data_tx (data_tx),
        .wen     (wen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] gnt;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [2:0] req;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [2:0] exp_gnt;
        logic [7:0] exp_data;
    } vec_t;

    exp_t       sb[$];
    int         n_vec   = 0;
    int         n_miss  = 0;
    int         cyc     = 0;
    int         n_gnt   = 0;
    int         gnt_cyc = 0;
    logic       pend    = 1'b0;
    logic [7:0] pend_data = 8'h00;
    logic [1:0] m_last  = 2'd2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_pick(input logic [2:0] r, input logic [1:0] last);
`ifdef BT_TX_ARB_FIXED_PRIO_EN
        if (r[0]) return 2'd0;
        if (r[1]) return 2'd1;
        return 2'd2;
`else
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (int'(last) + k) % 3;
            if (r[c]) return 2'(c);
        end
        return last;
`endif
    endfunction

    function automatic logic [7:0] data_of(input logic [1:0] idx);
        if (idx == 2'd0) return data0;
        if (idx == 2'd1) return data1;
        return data2;
    endfunction

    task automatic push_model(input logic [2:0] r);
        logic [1:0] idx;
        exp_t e;
        idx    = model_pick(r, m_last);
        m_last = idx;
        e.gnt  = 3'b001 << idx;
        e.data = data_of(idx);
        sb.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every grant and checks the strobe that must follow it.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            pend = 1'b0;
        end else begin
            check("wen", 32'(wen), pend ? 32'd0 : 32'd1);
            if (pend) begin
                check("strobe_data", 32'(data_tx), 32'(pend_data));
                pend = 1'b0;
            end
            if (sb.size() == 0) begin
                check("idle_gnt", 32'(gnt), 32'd0);
            end else if (gnt != 3'b000) begin
                e = sb.pop_front();
                check("gnt", 32'(gnt), 32'(e.gnt));
                check("load_data", 32'(data_tx), 32'(e.data));
                pend      = 1'b1;
                pend_data = e.data;
                gnt_cyc   = cyc;
                n_gnt++;
            end
        end
    end

    task automatic wait_gnt(output int c);
        int   start;
        logic got;
        start = n_gnt;
        got   = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            #1;
            if (n_gnt != start) got = 1'b1;
        end
        check("gnt_timeout", 32'(got), 32'd1);
        c = gnt_cyc;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        req = 3'b000;
        rst = 1'b1;
        m_last = 2'd2;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        vec_t vecs[10];
        int   c0, g, prev, start;

        vecs[0] = '{3'b010, 8'h00, 8'hA5, 8'h00, 3'b010, 8'hA5};
        vecs[1] = '{3'b111, 8'h11, 8'h22, 8'h33, 3'b100, 8'h33};
        vecs[2] = '{3'b111, 8'h44, 8'h55, 8'h66, 3'b001, 8'h44};
        vecs[3] = '{3'b111, 8'h77, 8'h88, 8'h99, 3'b010, 8'h88};
        vecs[4] = '{3'b111, 8'hAA, 8'hBB, 8'hCC, 3'b100, 8'hCC};
        vecs[5] = '{3'b011, 8'h01, 8'h02, 8'h03, 3'b001, 8'h01};
        vecs[6] = '{3'b101, 8'h10, 8'h20, 8'h30, 3'b100, 8'h30};
        vecs[7] = '{3'b001, 8'h5A, 8'h6B, 8'h7C, 3'b001, 8'h5A};
        vecs[8] = '{3'b110, 8'hC3, 8'h3C, 8'h96, 3'b010, 8'h3C};
        vecs[9] = '{3'b100, 8'hE1, 8'hE2, 8'hE3, 3'b100, 8'hE3};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_wen", 32'(wen), 32'd1);
        check("rst_data", 32'(data_tx), 32'd0);
        rst   = 1'b0;
        txrdy = 1'b1;
        @(posedge clk); #1;

        // Table: one transfer per vector, next request driven while the previous is in flight.
        prev = 0;
        for (int i = 0; i < 10; i++) begin
            c0    = cyc;
            req   = vecs[i].req;
            data0 = vecs[i].d0;
            data1 = vecs[i].d1;
            data2 = vecs[i].d2;
`ifdef BT_TX_ARB_FIXED_PRIO_EN
            push_model(vecs[i].req);
`else
            sb.push_back('{vecs[i].exp_gnt, vecs[i].exp_data});
            m_last = vecs[i].exp_gnt[0] ? 2'd0 : (vecs[i].exp_gnt[1] ? 2'd1 : 2'd2);
`endif
            wait_gnt(g);
            if (i == 0) check("first_latency", 32'(g - c0), 32'd2);
            else        check("period", 32'(g - prev), 32'(GUARD + 4));
            prev = g;
        end

        // Round-robin from reset with all requesters held.
        pulse_reset();
        data0 = 8'h3E;
        data1 = 8'h4F;
        data2 = 8'h5D;
        req   = 3'b111;
        for (int i = 0; i < 4; i++) push_model(3'b111);
        for (int i = 0; i < 4; i++) begin
            wait_gnt(g);
            if (i > 0) check("rr_period", 32'(g - prev), 32'(GUARD + 4));
            prev = g;
        end

        // Backpressure: txrdy low through the guard window and beyond.
        req   = 3'b001;
        txrdy = 1'b0;
        push_model(3'b001);
        start = n_gnt;
        repeat (20) @(negedge clk);
        check("bp_no_gnt", 32'(n_gnt), 32'(start));
        @(posedge clk); #1;
        txrdy = 1'b1;
        c0    = cyc;
        wait_gnt(g);
        check("bp_release", 32'(g - c0), 32'd3);

        // Reset landing in STROBE.
        req = 3'b000;
        @(posedge clk); #1;
        check("pre_rst_wen", 32'(wen), 32'd0);
        check("pre_rst_data", 32'(data_tx), 32'(data0));
        rst = 1'b1;
        #1;
        check("midrst_wen", 32'(wen), 32'd1);
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_data", 32'(data_tx), 32'd0);
        m_last = 2'd2;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        req = 3'b001;
        push_model(3'b001);
        wait_gnt(g);

        // req[2] raised and dropped entirely inside WAIT.
        req = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        req = 3'b100;
        @(posedge clk); #1;
        req = 3'b000;
        start = n_gnt;
        repeat (10) @(negedge clk);
        check("drop_no_gnt", 32'(n_gnt), 32'(start));
        req = 3'b111;
        push_model(3'b111);
        wait_gnt(g);
        req = 3'b000;

        repeat (8) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
